// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between fetch_sequencer (master), the instruction ROM and core/debug controls.
interface fetch_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       rom_addr;
    logic [31:0]      rom_data;
    logic             stall;
    logic             br_taken;
    logic [7:0]       br_target;
    logic             halt_req;
    logic             resume_req;
    logic             step_req;
    logic [7:0]       brk_addr;
    logic [31:0]      instr;
    logic [7:0]       instr_pc;
    logic             instr_valid;
    logic             halted;
    logic             null_hit;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid, halted, null_hit, fetch_cnt,
        input  rom_data, stall, br_taken, br_target, halt_req, resume_req, step_req, brk_addr
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid, halted, null_hit, fetch_cnt,
        output rom_data, stall, br_taken, br_target, halt_req, resume_req, step_req, brk_addr
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, one-entry fetch register, run/halt/step FSM, null-word stop.
// Optional PC breakpoint in RUN enabled by defining FETCH_BRKPT_EN.
module fetch_sequencer #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter bit          START_RUN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    fetch_sequencer_if.master   bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e           state_q;
    logic [7:0]       pc_q;
    logic [31:0]      instr_q;
    logic [7:0]       instr_pc_q;
    logic             instr_valid_q;
    logic             null_hit_q;
    logic [CNT_W-1:0] fetch_cnt_q;

    logic [CNT_W-1:0] fetch_cnt_d;
    logic [7:0]       pc_d;
    logic             brk_hit_c;
    logic             active_c;
    logic             block_c;
    logic             null_stop_c;
    logic             issue_c;

    assign fetch_cnt_d = (&fetch_cnt_q) ? fetch_cnt_q : fetch_cnt_q + CNT_W'(1);
    assign pc_d        = pc_q + 8'd4;

`ifdef FETCH_BRKPT_EN
    assign brk_hit_c = (pc_q[7:2] == bus.brk_addr[7:2]);
`else
    logic unused_brk;
    assign unused_brk = ^bus.brk_addr;
    assign brk_hit_c  = 1'b0;
`endif

    // Fetch decision for a non-stalled, non-redirected edge; halt/breakpoint only stop RUN.
    assign active_c    = (state_q == ST_RUN || state_q == ST_STEP) && !bus.br_taken && !bus.stall;
    assign block_c     = (state_q == ST_RUN) && (bus.halt_req || brk_hit_c);
    assign null_stop_c = active_c && !block_c && (bus.rom_data == 32'h0);
    assign issue_c     = active_c && !block_c && (bus.rom_data != 32'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= START_RUN ? ST_RUN : ST_HALT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 8'h00;
            instr_valid_q <= 1'b0;
            null_hit_q    <= 1'b0;
            fetch_cnt_q   <= '0;
        end else if (bus.br_taken) begin
            pc_q          <= {bus.br_target[7:2], 2'b00};
            instr_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            if (issue_c) begin
                instr_q       <= bus.rom_data;
                instr_pc_q    <= pc_q;
                instr_valid_q <= 1'b1;
                pc_q          <= pc_d;
                fetch_cnt_q   <= fetch_cnt_d;
                if (state_q == ST_STEP) begin
                    state_q <= ST_HALT;
                end
            end else if (null_stop_c) begin
                instr_valid_q <= 1'b0;
                null_hit_q    <= 1'b1;
                state_q       <= ST_HALT;
            end else if (block_c) begin
                instr_valid_q <= 1'b0;
                state_q       <= ST_HALT;
            end else if (state_q == ST_HALT) begin
                instr_valid_q <= 1'b0;
                // A step arriving with resume is dropped; halt beats resume.
                if (bus.resume_req && !bus.halt_req) begin
                    state_q    <= ST_RUN;
                    null_hit_q <= 1'b0;
                end else if (bus.step_req && !bus.resume_req) begin
                    state_q <= ST_STEP;
                end
            end
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.null_hit    = null_hit_q;
    assign bus.fetch_cnt   = fetch_cnt_q;
endmodule
